// File: rtl/mem_copy_if.sv
// mem_copy_if: control and decoder-bus signals of the block-copy engine
interface mem_copy_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [8:0]    length;
  logic [DW-1:0] rdata;
  logic [AW-1:0] address;
  logic          WR;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [8:0]    count;
  modport master (
    input  start, src_base, dst_base, length, rdata,
    output address, WR, wdata, busy, done, err, count
  );
  modport slave (
    output start, src_base, dst_base, length, rdata,
    input  address, WR, wdata, busy, done, err, count
  );
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: read-then-write block copy engine mastering the decoder address/WR bus
module mem_copy_dma #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAP_LIMIT = 768,
  parameter int MAX_LEN   = 256
) (
  input logic        clk,
  input logic        rst_n,
  mem_copy_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] RD    = 3'd2;
  localparam logic [2:0] RDW   = 3'd3;
  localparam logic [2:0] WRT   = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;
  logic [2:0]    state;
  logic [AW-1:0] src, dst;
  logic [8:0]    len, idx, count;
  logic [DW-1:0] cap;
  logic          err;
  logic [AW:0]   src_end, dst_end;
  logic          range_err;
  assign src_end   = {1'b0, src} + (AW+1)'(len);
  assign dst_end   = {1'b0, dst} + (AW+1)'(len);
  assign range_err = (len > 9'(MAX_LEN)) || (src_end > (AW+1)'(MAP_LIMIT)) || (dst_end > (AW+1)'(MAP_LIMIT));
  // sequencer: latch request, range-check, then read/wait/write per word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      idx   <= '0;
      cap   <= '0;
      err   <= 1'b0;
      count <= '0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          src   <= bus.src_base;
          dst   <= bus.dst_base;
          len   <= bus.length;
          err   <= 1'b0;
          count <= '0;
          state <= CHECK;
        end
        CHECK: begin
          idx   <= '0;
          err   <= range_err;
          state <= (range_err || len == '0) ? FIN : RD;
        end
        RD:  state <= RDW;
        RDW: begin
          cap   <= bus.rdata;
          state <= WRT;
        end
        WRT: begin
          idx   <= idx + 9'd1;
          count <= count + 9'd1;
          state <= (idx + 9'd1 == len) ? FIN : RD;
        end
        default: state <= IDLE;
      endcase
  assign bus.address = (state == RD || state == RDW) ? src + AW'(idx) : (state == WRT) ? dst + AW'(idx) : '0;
  assign bus.WR      = state == WRT;
  assign bus.wdata   = (state == WRT) ? cap : '0;
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == FIN;
  assign bus.err     = err;
  assign bus.count   = count;
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed copy scenarios checked cycle-by-cycle against an expected bus trace
module tb_mem_copy_dma;
  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic chk_en;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cyc0 = 0;
  int done_cyc = -1;
  int wr_cnt = 0;
  logic [31:0] tb_mem [1024];
  logic [31:0] mem_m [1024];
  exp_t q[$];
  exp_t e;
  logic err_m;
  logic [8:0] cnt_m;
  mem_copy_if #(.DW(32), .AW(32)) bus ();
  mem_copy_dma #(.DW(32), .AW(32), .MAP_LIMIT(768), .MAX_LEN(256)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    bus.rdata <= tb_mem[bus.address[9:0]];
    if (bus.WR) tb_mem[bus.address[9:0]] <= bus.wdata;
  end
  function automatic logic [31:0] init_val(int k);
    return 32'hA000_0000 | (k << 16) | k;
  endfunction
  function automatic void push(logic [31:0] a, logic wr, logic [31:0] wd, logic busy, logic done, logic err, logic [8:0] cnt);
    exp_t x;
    x.a = a; x.wr = wr; x.wd = wd; x.busy = busy; x.done = done; x.err = err; x.cnt = cnt;
    q.push_back(x);
  endfunction
  always @(negedge clk)
    if (chk_en && rst_n) begin
      if (q.size() != 0) e = q.pop_front();
      else begin
        e = '0;
        e.err = err_m;
        e.cnt = cnt_m;
      end
      checks++;
      if ({bus.address, bus.WR, bus.wdata, bus.busy, bus.done, bus.err, bus.count} !== e) begin
        errors++;
        $display("FAIL bus_trace cyc=%0d got addr=%h wr=%b wd=%h busy=%b done=%b err=%b cnt=%0d expected addr=%h wr=%b wd=%h busy=%b done=%b err=%b cnt=%0d",
          cyc, bus.address, bus.WR, bus.wdata, bus.busy, bus.done, bus.err, bus.count,
          e.a, e.wr, e.wd, e.busy, e.done, e.err, e.cnt);
      end
      if (bus.done) done_cyc = cyc;
      if (bus.WR) wr_cnt++;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n);
    logic bad;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.src_base = s;
    bus.dst_base = d;
    bus.length = n;
    cyc0 = cyc;
    wr_cnt = 0;
    done_cyc = -1;
    bad = (n > 256) || (longint'(s) + n > 768) || (longint'(d) + n > 768);
    push(0, 0, 0, 0, 0, err_m, cnt_m);
    push(0, 0, 0, 1, 0, 0, 0);
    if (!bad)
      for (int k = 0; k < n; k++) begin
        push(s + k, 0, 0, 1, 0, 0, 9'(k));
        push(s + k, 0, 0, 1, 0, 0, 9'(k));
        push(d + k, 1, mem_m[(s + k) % 1024], 1, 0, 0, 9'(k));
        mem_m[(d + k) % 1024] = mem_m[(s + k) % 1024];
      end
    push(0, 0, 0, 1, 1, bad, bad ? 9'd0 : n);
    err_m = bad;
    cnt_m = bad ? 9'd0 : n;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d trace entries left, expected 0", q.size());
      q.delete();
    end
    #1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.length = '0;
    rst_n = 1'b1;
    chk_en = 1'b0;
    err_m = 1'b0;
    cnt_m = '0;
    for (int k = 0; k < 1024; k++) begin
      tb_mem[k] = init_val(k);
      mem_m[k] = init_val(k);
    end
    #12 rst_n = 1'b0;
    #1;
    chk("rst_address", bus.address, 0);
    chk("rst_wr", 32'(bus.WR), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_count", 32'(bus.count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    start_xfer(0, 256, 4);
    wait_idle();
    chk("basic_writes", wr_cnt, 4);
    chk("basic_done_lat", done_cyc - cyc0, 14);
    chk("basic_count", 32'(bus.count), 4);
    chk("basic_mem259", tb_mem[259], 32'hA003_0003);
    start_xfer(10, 300, 0);
    wait_idle();
    chk("zero_writes", wr_cnt, 0);
    chk("zero_done_lat", done_cyc - cyc0, 2);
    start_xfer(0, 700, 100);
    wait_idle();
    chk("range_writes", wr_cnt, 0);
    chk("range_done_lat", done_cyc - cyc0, 2);
    repeat (4) @(posedge clk);
    #1 chk("range_err_sticky", 32'(bus.err), 1);
    start_xfer(32'hFFFF_FFF0, 0, 32);
    wait_idle();
    chk("wrap_err", 32'(bus.err), 1);
    start_xfer(0, 0, 300);
    wait_idle();
    chk("toolong_err", 32'(bus.err), 1);
    start_xfer(760, 100, 8);
    wait_idle();
    chk("edge_writes", wr_cnt, 8);
    chk("edge_err", 32'(bus.err), 0);
    start_xfer(0, 400, 3);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src_base = 50; bus.dst_base = 10; bus.length = 5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("busy_writes", wr_cnt, 3);
    chk("busy_mem402", tb_mem[402], 32'hA002_0002);
    chk("busy_mem10", tb_mem[10], 32'hA00A_000A);
    start_xfer(0, 600, 4);
    repeat (6) @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_address", bus.address, 0);
    chk("abort_wr", 32'(bus.WR), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_count", 32'(bus.count), 0);
    q.delete();
    err_m = 1'b0;
    cnt_m = '0;
    for (int k = 601; k < 604; k++) mem_m[k] = init_val(k);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("abort_mem600", tb_mem[600], 32'hA000_0000);
    chk("abort_mem601", tb_mem[601], 32'hA259_0259);
    repeat (3) @(posedge clk);
    start_xfer(0, 256, 256);
    wait_idle();
    chk("max_writes", wr_cnt, 256);
    chk("max_done_lat", done_cyc - cyc0, 770);
    chk("max_err", 32'(bus.err), 0);
    chk("max_count", 32'(bus.count), 256);
    chk("max_mem511", tb_mem[511], 32'hA0FF_00FF);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
